hazard_ctrl: RTL
================

# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core, successor to the combinational hazard detector. It produces EX-stage forwarding selects, detects load-use dependencies, and holds branch/jump flushes for a configurable number of slots. It also stretches stalls across multi-cycle cache misses without losing a flush that arrives during the miss, and keeps a saturating stall-cycle counter and a sticky miss-timeout flag. It sits beside the pipeline registers and drives their enable/flush controls via `hazType`.

## Interface
- `RAW`, 5: register-address width.
- `FLUSH_CYCLES`, 1: flush slots per taken branch/jump; legal range 1..7.
- `CNT_W`, 16: width of `stall_cycles`.
- `TIMEOUT`, 255: consecutive busy cycles before `timeout_err` sets; 0 disables the check.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `branch`, `jump`  in  1  taken branch/jump resolved this cycle.
- `cache_busy`  in  1  I- or D-cache miss in progress.
- `IF_ID_Rs`, `IF_ID_Rt`  in  RAW  source registers of the instruction in decode.
- `ID_EX_Rs`, `ID_EX_Rt`  in  RAW  source registers of the instruction in EX.
- `ID_EX_memRead`  in  1  EX instruction is a load; its destination is `ID_EX_Rt`.
- `EX_MEM_Rd`, `MEM_WB_Rd`  in  RAW  destination registers.
- `EX_MEM_regWen`, `MEM_WB_regWen`  in  1  register-write enables.
- `hazType`  out  2  0 none, 1 data stall (IF/ID), 2 flush IF/ID, 3 cache stall (IF..MEM).
- `fwdA`, `fwdB`  out  2  ALU operand select: 00 register file, 10 EX/MEM, 01 MEM/WB.
- `stall_cycles`  out  CNT_W  count of cycles with `hazType != 0`, saturating.
- `timeout_err`  out  1  sticky miss-timeout flag.

## Operation
- **Forwarding** (combinational, independent of FSM):
  - `fwdA` = 10 if `EX_MEM_regWen` and `EX_MEM_Rd != 0` and `EX_MEM_Rd == ID_EX_Rs`.
  - Otherwise `fwdA` = 01 if the same three conditions hold for MEM_WB.
  - Otherwise `fwdA` = 00.
  - `fwdB` is identical, using `ID_EX_Rt`. EX/MEM wins when both stages match.
- **Load-use:** `lu` = `ID_EX_memRead` and `ID_EX_Rt != 0` and (`ID_EX_Rt == IF_ID_Rs` or `ID_EX_Rt == IF_ID_Rt`).
- **Flush counter:** `fcnt`, 3 bits, holds flush slots still owed.
- **State:**
  - CWAIT when `cache_busy`.
  - FLUSH when `fcnt > 0`.
  - IDLE otherwise.
- **`hazType` priority:**
  1. `cache_busy` gives 3.
  2. Else (`branch` or `jump` or `fcnt > 0`) gives 2.
  3. Else `lu` gives 1.
  4. Else 0.
- **`fcnt` update:**
  - busy cycle with `branch|jump`: `fcnt <= FLUSH_CYCLES`. All slots are owed, because the flush was not delivered.
  - busy cycle without `branch|jump`: `fcnt` holds (frozen).
  - non-busy cycle with `branch|jump`: `fcnt <= FLUSH_CYCLES-1`. The current cycle is the first slot.
  - non-busy cycle with `fcnt > 0`: `fcnt <= fcnt-1`.
- **Miss counter:** `wcnt`, width clog2(TIMEOUT+1).
  - Increments each busy cycle and saturates.
  - Clears on any non-busy cycle.
  - When `wcnt == TIMEOUT-1` on a busy cycle (TIMEOUT > 0), `timeout_err <= 1`. It stays set until reset.
- **`stall_cycles`:** `+1` each cycle with `hazType != 0`; holds at 2^CNT_W-1.

## Timing
- Forwarding, `lu` and `hazType` are combinational from inputs and `fcnt`: zero latency.
- `fcnt`, `wcnt`, `stall_cycles` and `timeout_err` update on the rising edge.
- A branch in cycle N with `FLUSH_CYCLES = k` gives `hazType = 2` for cycles N..N+k-1, then normal priority from N+k.
- A branch during a miss gives `hazType = 3` until `cache_busy` drops, then exactly k cycles of 2.
- A new branch during an active flush restarts the window from that cycle.
- Simultaneous `lu` and flush: flush wins; the stall is not owed afterwards, because the squashed instruction cannot use the load result.
- Reset, asynchronous assert and also mid-flush or mid-miss: `fcnt`, `wcnt`, `stall_cycles` and `timeout_err` go to 0.
  - While `rst_n` is low, `hazType`, `fwdA` and `fwdB` are forced to 0.
  - Deassert is taken synchronously by the system.

## Test plan
- EX_MEM_Rd=8 with regWen, MEM_WB_Rd=8 with regWen, ID_EX_Rs=8, ID_EX_Rt=9 -> fwdA=10, fwdB=00. Repeat with EX_MEM_Rd=0 -> fwdA=01.
- ID_EX_memRead=1, ID_EX_Rt=5, IF_ID_Rt=5 for 1 cycle -> hazType=1 that cycle; stall_cycles 0->1. Repeat with ID_EX_Rt=0 -> hazType=0.
- FLUSH_CYCLES=3, branch pulsed in cycle 10 -> hazType=2 in cycles 10,11,12 and 0 in cycle 13. Second branch in cycle 11 -> 2 through cycle 13.
- cache_busy high cycles 20-24, jump pulsed in cycle 22, FLUSH_CYCLES=2 -> hazType=3 in 20-24, 2 in 25-26, 0 in 27.
- TIMEOUT=4, cache_busy held 4 cycles -> timeout_err=1 after the 4th busy edge and stays 1. With busy held only 3 cycles -> stays 0.
- CNT_W=3, hazard held 10 cycles -> stall_cycles saturates at 7. Reset pulsed mid-flush (fcnt=2) -> all counters 0 and hazType=0 after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: forwarding, load-use, flush slots, miss stall
module hazard_ctrl #(
  parameter int RAW          = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch,
  input  logic             jump,
  input  logic             cache_busy,
  input  logic [RAW-1:0]   IF_ID_Rs,
  input  logic [RAW-1:0]   IF_ID_Rt,
  input  logic [RAW-1:0]   ID_EX_Rs,
  input  logic [RAW-1:0]   ID_EX_Rt,
  input  logic             ID_EX_memRead,
  input  logic [RAW-1:0]   EX_MEM_Rd,
  input  logic [RAW-1:0]   MEM_WB_Rd,
  input  logic             EX_MEM_regWen,
  input  logic             MEM_WB_regWen,
  output logic [1:0]       hazType,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             timeout_err
);

  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [2:0] FC_FULL = 3'(FLUSH_CYCLES);
  localparam logic [2:0] FC_REST = 3'(FLUSH_CYCLES - 1);
  localparam logic [WW-1:0] W_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_CWAIT = 2'd2;

  logic [2:0]    fcnt;
  logic [WW-1:0] wcnt;
  logic [1:0]    state;
  logic          redirect;
  logic          lu;
  logic          ex_hit_a, wb_hit_a, ex_hit_b, wb_hit_b;

  assign ex_hit_a = EX_MEM_regWen && (EX_MEM_Rd != '0) && (EX_MEM_Rd == ID_EX_Rs);
  assign wb_hit_a = MEM_WB_regWen && (MEM_WB_Rd != '0) && (MEM_WB_Rd == ID_EX_Rs);
  assign ex_hit_b = EX_MEM_regWen && (EX_MEM_Rd != '0) && (EX_MEM_Rd == ID_EX_Rt);
  assign wb_hit_b = MEM_WB_regWen && (MEM_WB_Rd != '0) && (MEM_WB_Rd == ID_EX_Rt);

  assign redirect = branch | jump;
  assign lu = ID_EX_memRead && (ID_EX_Rt != '0) &&
              ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

  // EX/MEM holds the younger result, so it wins over MEM/WB
  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (rst_n) begin
      if (ex_hit_a)      fwdA = 2'b10;
      else if (wb_hit_a) fwdA = 2'b01;
      if (ex_hit_b)      fwdB = 2'b10;
      else if (wb_hit_b) fwdB = 2'b01;
    end
  end

  always_comb begin
    if (cache_busy)        state = S_CWAIT;
    else if (fcnt != 3'd0) state = S_FLUSH;
    else                   state = S_IDLE;
  end

  always_comb begin
    hazType = 2'd0;
    if (rst_n) begin
      case (state)
        S_CWAIT: hazType = 2'd3;
        S_FLUSH: hazType = 2'd2;
        default: begin
          if (redirect) hazType = 2'd2;
          else if (lu)  hazType = 2'd1;
        end
      endcase
    end
  end

  // A redirect seen during a miss was never delivered, so every slot is still owed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= 3'd0;
    end else if (cache_busy) begin
      if (redirect) fcnt <= FC_FULL;
    end else if (redirect) begin
      fcnt <= FC_REST;
    end else if (fcnt != 3'd0) begin
      fcnt <= fcnt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt        <= '0;
      timeout_err <= 1'b0;
    end else if (cache_busy) begin
      if (wcnt != '1) wcnt <= wcnt + WW'(1);
      if ((TIMEOUT > 0) && (wcnt == W_LAST)) timeout_err <= 1'b1;
    end else begin
      wcnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((hazType != 2'd0) && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
